// File: rtl/placement_eval.sv
`default_nettype none
// ============================================================================
// Module      : placement_eval
// Description : Walks a netlist edge list, fetches both endpoint positions
//               from a position memory and reduces the Manhattan edge lengths
//               (minus one) into either a saturating total or a maximum.
//               Unplaced (-1) and off-grid endpoints are flagged per run.
// Revision    : 1.0 - initial release
// ============================================================================
module placement_eval #(
    parameter int DW   = 32,
    parameter int EAW  = 4,
    parameter int NAW  = 4,
    parameter int GRID = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EAW:0]         n_edges,
    input  logic                 mode,
    output logic                 edge_re,
    output logic [EAW-1:0]       edge_addr,
    input  logic [NAW-1:0]       edge_a,
    input  logic [NAW-1:0]       edge_b,
    output logic                 pos_re,
    output logic [NAW-1:0]       pos_addr,
    input  logic signed [DW-1:0] pos_x,
    input  logic signed [DW-1:0] pos_y,
    output logic                 busy,
    output logic                 done,
    output logic [DW-1:0]        result,
    output logic                 err_unplaced,
    output logic                 err_bounds,
    output logic [EAW-1:0]       err_idx
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_EDGE = 3'd1,
        RD_A    = 3'd2,
        RD_B    = 3'd3,
        CALC    = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [EAW:0]         c_max_edges = {1'b1, {EAW{1'b0}}};
    localparam logic [EAW:0]         c_idx_one   = {{EAW{1'b0}}, 1'b1};
    localparam logic [DW-1:0]        c_sat       = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] c_neg1      = '1;
    localparam logic signed [DW-1:0] c_zero      = '0;
    localparam logic signed [DW-1:0] c_grid      = DW'(GRID);
    localparam logic signed [DW:0]   c_len_one   = {{DW{1'b0}}, 1'b1};

    state_t                 r_state;
    logic [EAW:0]           r_idx;
    logic [EAW:0]           r_count;
    logic                   r_mode;
    logic [NAW-1:0]         r_b;
    logic signed [DW-1:0]   r_xa;
    logic signed [DW-1:0]   r_ya;
    logic [DW-1:0]          r_result;
    logic                   r_err_unplaced;
    logic                   r_err_bounds;
    logic [EAW-1:0]         r_err_idx;
    logic                   r_busy;
    logic                   r_done;

    logic signed [DW:0]     w_dx;
    logic signed [DW:0]     w_dy;
    logic signed [DW:0]     w_adx;
    logic signed [DW:0]     w_ady;
    logic signed [DW:0]     w_dist;
    logic signed [DW:0]     w_len;
    logic [DW+1:0]          w_sum;
    logic [DW-1:0]          w_sat_sum;
    logic                   w_unplaced;
    logic                   w_oob;
    logic                   w_first_err;
    logic [EAW:0]           w_idx_nxt;
    logic [EAW:0]           w_count_clamped;

    function automatic logic f_oob(input logic signed [DW-1:0] v);
        return (v < c_zero) || (v >= c_grid);
    endfunction

    // Memory strobes are decoded from the state so the position address can
    // follow edge_a in the same cycle the edge data arrives.
    assign edge_re   = (r_state == RD_EDGE);
    assign edge_addr = edge_re ? r_idx[EAW-1:0] : '0;
    assign pos_re    = (r_state == RD_A) || (r_state == RD_B);
    assign pos_addr  = (r_state == RD_A) ? edge_a :
                       (r_state == RD_B) ? r_b    : '0;

    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign err_unplaced = r_err_unplaced;
    assign err_bounds   = r_err_bounds;
    assign err_idx      = r_err_idx;

    // Edge length at DW+1 bits: differences of two DW-bit values cannot wrap.
    assign w_dx   = {r_xa[DW-1], r_xa} - {pos_x[DW-1], pos_x};
    assign w_dy   = {r_ya[DW-1], r_ya} - {pos_y[DW-1], pos_y};
    assign w_adx  = w_dx[DW] ? -w_dx : w_dx;
    assign w_ady  = w_dy[DW] ? -w_dy : w_dy;
    assign w_dist = w_adx + w_ady - c_len_one;
    assign w_len  = w_dist[DW] ? '0 : w_dist;

    // Saturating accumulation; w_len is non-negative so its bits extend as unsigned.
    assign w_sum     = {2'b00, r_result} + {1'b0, w_len};
    assign w_sat_sum = (w_sum > {2'b00, c_sat}) ? c_sat : w_sum[DW-1:0];

    // Unplaced takes precedence over out-of-bounds for the same edge.
    assign w_unplaced  = (r_xa == c_neg1) || (r_ya == c_neg1) ||
                         (pos_x == c_neg1) || (pos_y == c_neg1);
    assign w_oob       = f_oob(r_xa) || f_oob(r_ya) || f_oob(pos_x) || f_oob(pos_y);
    assign w_first_err = !r_err_unplaced && !r_err_bounds;

    assign w_idx_nxt       = r_idx + c_idx_one;
    assign w_count_clamped = (n_edges > c_max_edges) ? c_max_edges : n_edges;

    // Control FSM with the accumulator, error flags and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_count        <= '0;
            r_mode         <= 1'b0;
            r_b            <= '0;
            r_xa           <= '0;
            r_ya           <= '0;
            r_result       <= '0;
            r_err_unplaced <= 1'b0;
            r_err_bounds   <= 1'b0;
            r_err_idx      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            // busy covers the done cycle and falls together with done
            if (r_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // busy still high during the done cycle blocks re-acceptance
                    if (start && !r_busy) begin
                        r_result       <= '0;
                        r_err_unplaced <= 1'b0;
                        r_err_bounds   <= 1'b0;
                        r_err_idx      <= '0;
                        r_idx          <= '0;
                        r_mode         <= mode;
                        r_count        <= w_count_clamped;
                        r_busy         <= 1'b1;
                        r_state        <= (w_count_clamped == '0) ? FIN : RD_EDGE;
                    end
                end
                RD_EDGE: begin
                    r_state <= RD_A;
                end
                RD_A: begin
                    r_b     <= edge_b;
                    r_state <= RD_B;
                end
                RD_B: begin
                    r_xa    <= pos_x;
                    r_ya    <= pos_y;
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_unplaced) begin
                        r_err_unplaced <= 1'b1;
                        if (w_first_err) begin
                            r_err_idx <= r_idx[EAW-1:0];
                        end
                    end else if (w_oob) begin
                        r_err_bounds <= 1'b1;
                        if (w_first_err) begin
                            r_err_idx <= r_idx[EAW-1:0];
                        end
                    end else if (r_mode) begin
                        if (w_len > $signed({1'b0, r_result})) begin
                            r_result <= w_len[DW-1:0];
                        end
                    end else begin
                        r_result <= w_sat_sum;
                    end
                    r_idx   <= w_idx_nxt;
                    r_state <= (w_idx_nxt == r_count) ? FIN : RD_EDGE;
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_placement_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_placement_eval
// Description : Directed bench for placement_eval with behavioural edge and
//               position memories, a vector table and hand-written sequences
//               for held start and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_placement_eval;

    localparam int DW   = 32;
    localparam int EAW  = 4;
    localparam int NAW  = 4;
    localparam int GRID = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [EAW:0]         n_edges = '0;
    logic                 mode = 1'b0;
    logic                 edge_re;
    logic [EAW-1:0]       edge_addr;
    logic [NAW-1:0]       edge_a = '0;
    logic [NAW-1:0]       edge_b = '0;
    logic                 pos_re;
    logic [NAW-1:0]       pos_addr;
    logic signed [DW-1:0] pos_x = '0;
    logic signed [DW-1:0] pos_y = '0;
    logic                 busy;
    logic                 done;
    logic [DW-1:0]        result;
    logic                 err_unplaced;
    logic                 err_bounds;
    logic [EAW-1:0]       err_idx;

    logic [NAW-1:0]       mem_ea [16];
    logic [NAW-1:0]       mem_eb [16];
    logic signed [DW-1:0] mem_px [16];
    logic signed [DW-1:0] mem_py [16];

    int total = 0;
    int bad   = 0;
    int re_cnt = 0;

    placement_eval #(.DW(DW), .EAW(EAW), .NAW(NAW), .GRID(GRID)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n_edges      (n_edges),
        .mode         (mode),
        .edge_re      (edge_re),
        .edge_addr    (edge_addr),
        .edge_a       (edge_a),
        .edge_b       (edge_b),
        .pos_re       (pos_re),
        .pos_addr     (pos_addr),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .err_unplaced (err_unplaced),
        .err_bounds   (err_bounds),
        .err_idx      (err_idx)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= mem_ea[edge_addr];
            edge_b <= mem_eb[edge_addr];
            re_cnt <= re_cnt + 1;
        end
        if (pos_re) begin
            pos_x <= mem_px[pos_addr];
            pos_y <= mem_py[pos_addr];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edges (0,1),(1,2),(0,2); remaining entries are self-loops on node 0.
    task automatic load_edges();
        for (int i = 0; i < 16; i++) begin
            mem_ea[i] = '0;
            mem_eb[i] = '0;
        end
        mem_ea[0] = 4'd0; mem_eb[0] = 4'd1;
        mem_ea[1] = 4'd1; mem_eb[1] = 4'd2;
        mem_ea[2] = 4'd0; mem_eb[2] = 4'd2;
    endtask

    task automatic set_pos(input int scen);
        for (int i = 0; i < 16; i++) begin
            mem_px[i] = 0;
            mem_py[i] = 0;
        end
        mem_px[1] = 2;  mem_py[1] = 0;
        mem_px[2] = 2;  mem_py[2] = 3;
        case (scen)
            1: begin mem_px[2] = -1; mem_py[2] = -1; end
            2: begin mem_px[1] = 16; end
            3: begin mem_px[2] = 15; mem_py[2] = 15; end
            4: begin mem_px[1] = -2; end
            5: begin mem_px[1] = 16; mem_px[2] = -1; mem_py[2] = -1; end
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // Launch one run and return the done latency in clocks (-1 on timeout).
    task automatic run_once(input int n, input bit m, output int lat);
        wait_idle();
        n_edges = 5'(n);
        mode    = m;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        int scen;
        int n;
        bit m;
        int exp_res;
        bit exp_u;
        bit exp_b;
        int exp_idx;
        int exp_lat;
        int exp_re;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat;
        int re_base;
        int done_seen;
        int first_done;
        int second_done;
        int res1;
        int res2;
        int busy13;
        int busy14;

        vecs[0]  = '{0,  3, 1'b0,  7, 1'b0, 1'b0, 0, 13,  3};
        vecs[1]  = '{0,  3, 1'b1,  4, 1'b0, 1'b0, 0, 13,  3};
        vecs[2]  = '{1,  3, 1'b0,  1, 1'b1, 1'b0, 1, 13,  3};
        vecs[3]  = '{2,  3, 1'b0,  4, 1'b0, 1'b1, 0, 13,  3};
        vecs[4]  = '{5,  3, 1'b0,  0, 1'b1, 1'b1, 0, 13,  3};
        vecs[5]  = '{0,  0, 1'b0,  0, 1'b0, 1'b0, 0,  1,  0};
        vecs[6]  = '{0,  1, 1'b0,  1, 1'b0, 1'b0, 0,  5,  1};
        vecs[7]  = '{0,  2, 1'b1,  2, 1'b0, 1'b0, 0,  9,  2};
        vecs[8]  = '{1,  3, 1'b1,  1, 1'b1, 1'b0, 1, 13,  3};
        vecs[9]  = '{0, 31, 1'b0,  7, 1'b0, 1'b0, 0, 65, 16};
        vecs[10] = '{3,  3, 1'b0, 57, 1'b0, 1'b0, 0, 13,  3};
        vecs[11] = '{3,  3, 1'b1, 29, 1'b0, 1'b0, 0, 13,  3};
        vecs[12] = '{4,  3, 1'b0,  4, 1'b0, 1'b1, 0, 13,  3};

        load_edges();
        set_pos(0);

        // Reset values while reset is held low
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err_unplaced", err_unplaced, 0);
        chk("rst_err_bounds", err_bounds, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_edge_re", edge_re, 0);
        chk("rst_edge_addr", edge_addr, 0);
        chk("rst_pos_re", pos_re, 0);
        chk("rst_pos_addr", pos_addr, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven runs
        for (int v = 0; v < 13; v++) begin
            set_pos(vecs[v].scen);
            re_base = re_cnt;
            run_once(vecs[v].n, vecs[v].m, lat);
            chk($sformatf("v%0d_result", v), result, vecs[v].exp_res);
            chk($sformatf("v%0d_err_unplaced", v), err_unplaced, vecs[v].exp_u);
            chk($sformatf("v%0d_err_bounds", v), err_bounds, vecs[v].exp_b);
            chk($sformatf("v%0d_err_idx", v), err_idx, vecs[v].exp_idx);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_busy_in_done", v), busy, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_edge_reads", v), re_cnt - re_base, vecs[v].exp_re);
            chk($sformatf("v%0d_done_pulse", v), done, 0);
        end

        // Start held high for 20 cycles: one run, then re-accepted after done
        set_pos(0);
        wait_idle();
        n_edges = 5'd3;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        done_seen = 0; first_done = -1; second_done = -1;
        res1 = -1; res2 = -1; busy13 = -1; busy14 = -1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (c == 19) start = 1'b0;
            if (c == 13) busy13 = busy;
            if (c == 14) busy14 = busy;
            if (done) begin
                done_seen++;
                if (first_done < 0) begin
                    first_done = c; res1 = result;
                end else if (second_done < 0) begin
                    second_done = c; res2 = result;
                end
            end
        end
        start = 1'b0;
        chk("held_first_done", first_done, 13);
        chk("held_first_result", res1, 7);
        chk("held_busy_done_cycle", busy13, 1);
        chk("held_busy_after_done", busy14, 0);
        chk("held_second_done", second_done, 28);
        chk("held_second_result", res2, 7);
        chk("held_done_count", done_seen, 2);

        // Reset pulse during the second edge aborts the run silently
        wait_idle();
        n_edges = 5'd3;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_pos_re_before", pos_re, 1);
        chk("mid_result_before", result, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_result", result, 0);
        chk("mid_pos_re", pos_re, 0);
        chk("mid_pos_addr", pos_addr, 0);
        chk("mid_edge_re", edge_re, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("mid_no_done", done_seen, 0);
        chk("mid_idle_busy", busy, 0);
        run_once(3, 1'b0, lat);
        chk("post_rst_result", result, 7);
        chk("post_rst_latency", lat, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
